// File: rtl/amber48_pkg.sv
// amber48 core shared definitions: register-file geometry and regfile state type.
package amber48_pkg;

  localparam int XLEN           = 48;
  localparam int REG_COUNT      = 16;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  // Core default port counts for the multi-port register file
  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 1;

  typedef enum logic {RF_INIT, RF_RUN} amber48_rf_state_e;

endpackage

// File: rtl/amber48_rf_scoreboard.sv
// Load-use scoreboard: one busy bit per architectural register.
// Priority per register: flush > reserve > write clear > hold. Bit 0 is always 0.
module amber48_rf_scoreboard
  import amber48_pkg::*;
#(
  parameter int REG_COUNT = amber48_pkg::REG_COUNT,
  parameter int NUM_WR    = amber48_pkg::RF_NUM_WR,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   rsv_valid_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic [NUM_WR-1:0]      we_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  output logic [REG_COUNT-1:0]   busy_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] wr_hit;

  // Decode which registers are targeted by any enabled write port
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (we_i[w]) wr_hit[wr_addr_i[w*AW +: AW]] = 1'b1;
    end
  end

  // Next busy vector; a younger reservation beats a same-cycle write clear
  always_comb begin
    busy_d = busy_q;
    if (en_i) begin
      if (flush_i) begin
        busy_d = '0;
      end else begin
        for (int r = 1; r < REG_COUNT; r++) begin
          if (rsv_valid_i && (rsv_addr_i == AW'(r))) busy_d[r] = 1'b1;
          else if (wr_hit[r])                        busy_d[r] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/amber48_regfile_mp.sv
// amber48 multi-port register file: RAM-mappable storage cleared by a
// sequential init walk, combinational reads with optional write bypass,
// hardwired zero register and a load-use scoreboard.
module amber48_regfile_mp
  import amber48_pkg::*;
#(
  parameter int XLEN      = amber48_pkg::XLEN,
  parameter int REG_COUNT = amber48_pkg::REG_COUNT,
  parameter int NUM_RD    = amber48_pkg::RF_NUM_RD,
  parameter int NUM_WR    = amber48_pkg::RF_NUM_WR,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     ready_o,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     rsv_valid_i,
  input  logic [AW-1:0]            rsv_addr_i,
  input  logic                     flush_i,
  output logic [REG_COUNT-1:0]     sb_busy_o
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
  localparam logic [AW-1:0] LAST_A = AW'(REG_COUNT - 1);

  amber48_rf_state_e   state_q;
  logic [AW-1:0]       clr_idx_q;
  logic                ready_q;
  logic                run;
  logic [XLEN-1:0]     mem_q [REG_COUNT];
  logic [REG_COUNT-1:0] sb_q;

  assign run     = (state_q == RF_RUN);
  assign ready_o = ready_q;

  // Init FSM: walk every entry once after reset, then stay in RUN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RF_INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_A) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: state_q <= RF_RUN;
        default: state_q <= RF_INIT;
      endcase
    end
  end

  // Storage: clear walk during init, port writes in RUN (highest port wins)
  always_ff @(posedge clk_i) begin
    if (!run) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we_i[w] && (wr_addr_i[w*AW +: AW] != ZERO_A))
          mem_q[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
      end
    end
  end

  // Read ports: zero during init and for REG_ZERO, else bypass or stored value
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    rd_data_o = '0;
    rd_busy_o = '0;
    a = '0;
    d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rd_addr_i[k*AW +: AW];
      d = '0;
      if (run && (a != ZERO_A)) begin
        d = mem_q[a];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (we_i[w] && (wr_addr_i[w*AW +: AW] == a)) d = wr_data_i[w*XLEN +: XLEN];
          end
        end
        rd_busy_o[k] = sb_q[a];
      end
      rd_data_o[k*XLEN +: XLEN] = d;
    end
  end

  amber48_rf_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_WR    (NUM_WR)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (run),
    .flush_i     (flush_i),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i),
    .we_i        (we_i),
    .wr_addr_i   (wr_addr_i),
    .busy_o      (sb_q)
  );

  assign sb_busy_o = sb_q;

endmodule

// File: doc/amber48_regfile_mp.md
Name: amber48_regfile_mp

Overview:
Parametrised multi-port register file for the amber48 core. It is the successor to the fixed 2-read/1-write regfile request path. Read and write port counts, depth and width are configurable. It adds same-cycle write-to-read bypass, hardwired REG_ZERO, a load-use scoreboard, and a sequential clear state machine so the storage can map to RAM. It sits between decode (reads, reservations) and writeback (writes).

Parameters:
XLEN, 48, data width in bits
REG_COUNT, 16, number of architectural registers (power of two, >=2)
NUM_RD, 2, read ports
NUM_WR, 1, write ports
BYPASS, 1, 1 = a same-cycle write is visible on reads; 0 = the read returns the stored value

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
ready_o  out  1  high once the clear sequence has finished
rd_addr_i  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW], AW = $clog2(REG_COUNT)
rd_data_o  out  NUM_RD*XLEN  read data, combinational
rd_busy_o  out  NUM_RD  scoreboard busy bit of each read address
we_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR*AW  write addresses
wr_data_i  in  NUM_WR*XLEN  write data
rsv_valid_i  in  1  reserve a destination, e.g. a load issued
rsv_addr_i  in  AW  register to reserve
flush_i  in  1  clear all scoreboard bits
sb_busy_o  out  REG_COUNT  full scoreboard vector

Behaviour:
- Reset (rst_ni=0, async): state=RF_INIT, clear index=0, ready_o=0, sb_busy_o=0. Storage has no reset.
- RF_INIT: each edge writes 0 to entry[clear index] and increments the index. The edge that clears index REG_COUNT-1 moves the state to RF_RUN, and ready_o=1 from that edge on. ready_o therefore rises after exactly REG_COUNT edges following reset release.
- During RF_INIT:
  - we_i, rsv_valid_i and flush_i are ignored.
  - rd_data_o is all zeros and rd_busy_o=0.
- RF_RUN is terminal; only reset leaves it.
- Reads: zero latency, combinational.
  - Address REG_ZERO always returns 0 and busy=0.
  - If BYPASS=1 and some enabled write port targets the same nonzero address this cycle, return that port's wr_data_i. Otherwise return the stored entry.
- Writes commit on the rising edge.
  - Writes to REG_ZERO are dropped.
  - If several ports write the same address in one cycle, the highest port index wins, for both bypass and storage.
- Scoreboard (RF_RUN only), per nonzero register r, evaluated each edge:
  - flush_i=1: all bits go to 0. Reserve and write clears are ignored that cycle.
  - else if rsv_valid_i and rsv_addr_i==r: set to 1. A reserve wins over a same-cycle write clear, because the younger reservation takes priority.
  - else if any enabled write targets r: clear to 0.
  - else: hold.
  - Reserving REG_ZERO has no effect; bit 0 is constant 0.
- rd_busy_o reflects registered scoreboard state only. It does not bypass a same-cycle write clear.
- Reset mid-operation: reset asynchronously drops ready_o and clears the scoreboard, then re-runs the full clear sequence.

Decomposition:
- Add to amber48_pkg:
  - typedef enum logic {RF_INIT, RF_RUN} amber48_rf_state_e
  - localparam RF_NUM_RD=2, RF_NUM_WR=1 as core defaults
- Reuse the existing REG_COUNT, REG_ADDR_WIDTH and REG_ZERO.
- Sub-module amber48_rf_scoreboard holds the busy vector with flush/reserve/clear priority. It is parametrised on REG_COUNT and NUM_WR.
- Storage, bypass mux and init FSM live in the top module.

Test Plan:
1. Init: release reset with REG_COUNT=16 → ready_o=0 for 16 edges, 1 after the 16th. All reads return 0 during and after init. A write of 0xABC issued during init is not stored.
2. Write/read and zero: write r3=0x0000_1234_5678 → the next cycle reads 0x0000_1234_5678. Write r0=0xFFFF_FFFF_FFFF → a read of r0 returns 0.
3. Bypass:
   - BYPASS=1: write r5=0x55 and read r5 in the same cycle → 0x55.
   - BYPASS=0: the same-cycle read returns the old value (0). The next cycle reads 0x55.
4. Multi-write, NUM_WR=2: both ports write r7 (0x11 on port0, 0x22 on port1) → bypass read and stored value are both 0x22.
5. Scoreboard:
   - Reserve r4 → sb_busy_o[4]=1 next cycle.
   - Same-cycle reserve r4 plus write r4 → stays 1.
   - Write r4 alone → 0.
   - Reserve r0 → stays 0.
   - flush_i with reserve r9 → all bits 0.
6. Reset mid-run: reserve r2, write r6=0x66, assert rst_ni=0 for 1 cycle → ready_o=0 and sb_busy_o=0 immediately. After 16 edges ready_o=1 and r6 reads 0.
